// File: rtl/tmds_video_scheduler_pkg.sv
// hdmi_pkg: shared definitions for the TMDS video scheduler.
//   - default 720p raster timing
//   - scheduler FSM state encoding
//   - counter and pixel widths
//   - channel-to-colour byte mapping (ch0=B, ch1=G, ch2=R)
package hdmi_pkg;

    localparam int HCNT_W = 12;
    localparam int VCNT_W = 11;
    localparam int PIX_W  = 24;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SYNC_WAIT = 2'd1,
        ST_RUN       = 2'd2
    } sched_state_e;

    // Byte lane carried by each TMDS channel within {R,G,B}.
    localparam logic [1:0] CH0_LANE = 2'd0;   // blue
    localparam logic [1:0] CH1_LANE = 2'd1;   // green
    localparam logic [1:0] CH2_LANE = 2'd2;   // red

    function automatic logic [7:0] chan_byte(input logic [PIX_W-1:0] rgb,
                                             input logic [1:0]       lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = rgb[7:0];
            2'd1:    b = rgb[15:8];
            default: b = rgb[23:16];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tmds_video_scheduler_if.sv
// pix_stream_if: upstream pixel stream (valid/ready with start-of-frame).
//   pix_data_in   {R[23:16],G[15:8],B[7:0]}
//   pix_valid_in  pixel valid
//   pix_sof_in    qualifies the first pixel of a frame
//   pix_ready_out pixel consumed when valid & ready
// master = pixel source, slave = scheduler.
interface pix_stream_if;
    logic [hdmi_pkg::PIX_W-1:0] pix_data_in;
    logic                       pix_valid_in;
    logic                       pix_sof_in;
    logic                       pix_ready_out;

    modport master (
        output pix_data_in, pix_valid_in, pix_sof_in,
        input  pix_ready_out
    );

    modport slave (
        input  pix_data_in, pix_valid_in, pix_sof_in,
        output pix_ready_out
    );
endinterface

// File: rtl/tmds_video_scheduler_timing.sv
// video_timing_gen: raster h/v counters and active/hsync/vsync decode.
//   clk_i, rst_n_i  clock, async active-low reset
//   en_i            advance counters this cycle
//   clr_i           synchronous clear to (0,0), wins over en_i
//   h_o, v_o        current counter position
//   active_o        position is inside active video
//   hsync_o/vsync_o raw sync windows (active-high, polarity applied by user)
module video_timing_gen
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              clr_i,
    output logic [HCNT_W-1:0] h_o,
    output logic [VCNT_W-1:0] v_o,
    output logic              active_o,
    output logic              hsync_o,
    output logic              vsync_o
);

    localparam logic [HCNT_W-1:0] H_ACT   = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_SYN_S = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] H_SYN_E = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VCNT_W-1:0] V_ACT   = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_SYN_S = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] V_SYN_E = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VCNT_W-1:0] V_LAST  = VCNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [HCNT_W-1:0] h_q;
    logic [VCNT_W-1:0] v_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_q <= '0;
            v_q <= '0;
        end else if (clr_i) begin
            h_q <= '0;
            v_q <= '0;
        end else if (en_i) begin
            if (h_q == H_LAST) begin
                h_q <= '0;
                v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    assign h_o      = h_q;
    assign v_o      = v_q;
    assign active_o = (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_o  = (h_q >= H_SYN_S) && (h_q < H_SYN_E);
    assign vsync_o  = (v_q >= V_SYN_S) && (v_q < V_SYN_E);

endmodule

// File: rtl/tmds_video_scheduler.sv
// tmds_video_scheduler: raster timing and pixel scheduling for three TMDS
// encoders. Pulls pixels from the upstream stream aligned to start-of-frame,
// drives colour bytes in active video and control codes (sync on ch0) in
// blanking. All outputs except pix_ready_out are registered one cycle after
// the counter position they describe.
//   clk_1x_in, rst_n_in     pixel clock, async active-low reset
//   enable_in               run timing; low forces IDLE
//   pix                     upstream pixel stream (slave side)
//   ch0/1/2_data_out        B / G / R bytes to encoders
//   ch0_ctrl_out            {vsync,hsync} at polarity; ch1/ch2 ctrl are 0
//   blanking_out            1 outside active video
//   hcount_out, vcount_out  position of the current outputs
//   frame_start_out         pulse with the outputs for (0,0)
//   underflow_out           sticky: active cycle with no pixel in RUN
//   misalign_out            sticky: sof off (0,0), or non-sof at (0,0)
//   clear_flags_in          clears both flags; a same-cycle set wins
//
// state        | meaning
// ST_IDLE      | disabled; counters held at 0, outputs quiescent
// ST_SYNC_WAIT | timing runs, fill colour shown; flushing until sof at (0,0)
// ST_RUN       | aligned; active pixels come from the stream
module tmds_video_scheduler
    import hdmi_pkg::*;
#(
    parameter int          H_ACTIVE  = H_ACTIVE_720P,
    parameter int          H_FP      = H_FP_720P,
    parameter int          H_SYNC    = H_SYNC_720P,
    parameter int          H_BP      = H_BP_720P,
    parameter int          V_ACTIVE  = V_ACTIVE_720P,
    parameter int          V_FP      = V_FP_720P,
    parameter int          V_SYNC    = V_SYNC_720P,
    parameter int          V_BP      = V_BP_720P,
    parameter logic        HSYNC_POL = 1'b1,
    parameter logic        VSYNC_POL = 1'b1,
    parameter logic [23:0] FILL_RGB  = 24'h000000
) (
    input  logic              clk_1x_in,
    input  logic              rst_n_in,
    input  logic              enable_in,
    pix_stream_if.slave       pix,
    output logic [7:0]        ch0_data_out,
    output logic [7:0]        ch1_data_out,
    output logic [7:0]        ch2_data_out,
    output logic [1:0]        ch0_ctrl_out,
    output logic [1:0]        ch1_ctrl_out,
    output logic [1:0]        ch2_ctrl_out,
    output logic              blanking_out,
    output logic [HCNT_W-1:0] hcount_out,
    output logic [VCNT_W-1:0] vcount_out,
    output logic              frame_start_out,
    output logic              underflow_out,
    output logic              misalign_out,
    input  logic              clear_flags_in
);

    localparam logic [1:0] CTRL_IDLE = {~VSYNC_POL, ~HSYNC_POL};

    logic [HCNT_W-1:0] h;
    logic [VCNT_W-1:0] v;
    logic              active, hsync, vsync, origin;

    // Counters run whenever enabled, so the cycle that raises enable_in is
    // already position (0,0) even though the FSM is still leaving IDLE.
    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i    (clk_1x_in),
        .rst_n_i  (rst_n_in),
        .en_i     (enable_in),
        .clr_i    (~enable_in),
        .h_o      (h),
        .v_o      (v),
        .active_o (active),
        .hsync_o  (hsync),
        .vsync_o  (vsync)
    );

    assign origin = (h == '0) && (v == '0);

    sched_state_e state_q, state_d;
    logic         ready_c, take_pix, set_uf, set_mis;
    logic [23:0]  pix_rgb;

    logic [7:0]        ch0_q, ch1_q, ch2_q;
    logic [1:0]        ctrl_q;
    logic              blank_q, fs_q, uf_q, mis_q;
    logic [HCNT_W-1:0] hcnt_q;
    logic [VCNT_W-1:0] vcnt_q;

    always_comb begin
        state_d  = state_q;
        ready_c  = 1'b0;
        take_pix = 1'b0;
        set_uf   = 1'b0;
        set_mis  = 1'b0;
        if (!enable_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC_WAIT;
                ST_SYNC_WAIT: begin
                    // Non-sof pixels are flushed; a sof pixel waits for (0,0).
                    if (active && pix.pix_valid_in && (!pix.pix_sof_in || origin)) begin
                        ready_c = 1'b1;
                        if (pix.pix_sof_in) begin
                            take_pix = 1'b1;
                            state_d  = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (active) begin
                        if (pix.pix_valid_in && pix.pix_sof_in && !origin) begin
                            set_mis = 1'b1;
                            state_d = ST_SYNC_WAIT;
                        end else begin
                            ready_c = 1'b1;
                            if (pix.pix_valid_in) begin
                                take_pix = 1'b1;
                                set_mis  = origin && !pix.pix_sof_in;
                            end else begin
                                set_uf = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign pix_rgb = take_pix ? pix.pix_data_in : FILL_RGB;

    always_ff @(posedge clk_1x_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            ch0_q   <= '0;
            ch1_q   <= '0;
            ch2_q   <= '0;
            ctrl_q  <= CTRL_IDLE;
            blank_q <= 1'b1;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            uf_q    <= set_uf  | (uf_q  & ~clear_flags_in);
            mis_q   <= set_mis | (mis_q & ~clear_flags_in);
            if (!enable_in) begin
                ch0_q   <= '0;
                ch1_q   <= '0;
                ch2_q   <= '0;
                ctrl_q  <= CTRL_IDLE;
                blank_q <= 1'b1;
                hcnt_q  <= '0;
                vcnt_q  <= '0;
                fs_q    <= 1'b0;
            end else begin
                ch0_q   <= active ? chan_byte(pix_rgb, CH0_LANE) : 8'h00;
                ch1_q   <= active ? chan_byte(pix_rgb, CH1_LANE) : 8'h00;
                ch2_q   <= active ? chan_byte(pix_rgb, CH2_LANE) : 8'h00;
                ctrl_q  <= {vsync ? VSYNC_POL : ~VSYNC_POL,
                            hsync ? HSYNC_POL : ~HSYNC_POL};
                blank_q <= ~active;
                hcnt_q  <= h;
                vcnt_q  <= v;
                fs_q    <= origin;
            end
        end
    end

    assign pix.pix_ready_out = ready_c;
    assign ch0_data_out      = ch0_q;
    assign ch1_data_out      = ch1_q;
    assign ch2_data_out      = ch2_q;
    assign ch0_ctrl_out      = ctrl_q;
    assign ch1_ctrl_out      = 2'b00;
    assign ch2_ctrl_out      = 2'b00;
    assign blanking_out      = blank_q;
    assign hcount_out        = hcnt_q;
    assign vcount_out        = vcnt_q;
    assign frame_start_out   = fs_q;
    assign underflow_out     = uf_q;
    assign misalign_out      = mis_q;

endmodule

// File: doc/tmds_video_scheduler.md
Name: tmds_video_scheduler

Overview:
- Sequences the three per-channel TMDS encoders.
- Generates raster timing (h/v counters, hsync/vsync, blanking) and presents colour bytes during active video; presents control codes, with sync on channel 0, during blanking.
- Pulls pixels from the upstream valid/ready stream with start-of-frame alignment, substitutes a fill colour on underflow and flags misalignment.
- Sits between the frame/line buffer and the encoder bank in the HDMI output path.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HSYNC_POL, 1, hsync asserted level
- VSYNC_POL, 1, vsync asserted level
- FILL_RGB, 24'h000000, colour driven on underflow or misalignment

Ports:
- clk_1x_in  in  1  pixel clock
- rst_n_in  in  1  reset, asynchronous, active-low
- enable_in  in  1  run timing; low forces IDLE
- pix_data_in  in  24  {R[23:16],G[15:8],B[7:0]}
- pix_valid_in  in  1  upstream pixel valid
- pix_sof_in  in  1  qualifies first pixel of frame
- pix_ready_out  out  1  pixel consumed when valid&ready
- ch0_data_out / ch1_data_out / ch2_data_out  out  8 each  B / G / R to encoders
- ch0_ctrl_out  out  2  {vsync,hsync} at polarity
- ch1_ctrl_out, ch2_ctrl_out  out  2 each  constant 2'b00
- blanking_out  out  1  1 outside active video
- hcount_out  out  12  h position of current outputs
- vcount_out  out  11  v position of current outputs
- frame_start_out  out  1  1-cycle pulse with outputs for (0,0)
- underflow_out  out  1  sticky; active cycle with no valid pixel
- misalign_out  out  1  sticky; sof at wrong position or missing at (0,0)
- clear_flags_in  in  1  clears both sticky flags; set wins if same cycle

Behaviour:
- Reset, and enable_in low: state IDLE; counters 0; blanking_out 1; ch*_data_out 0; ch0_ctrl_out at inactive polarity; counts 0; frame_start_out, pix_ready_out 0. Flags reset only by rst_n_in.
- Counters (h,v):
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - h increments every cycle when enabled and wraps at H_TOTAL-1; v increments on h wrap and wraps at V_TOTAL-1.
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync by line, same rule.
- All outputs are registered: latency 1 cycle from counter state; hcount_out/vcount_out are the counter values of that registered cycle. pix_ready_out is combinational from state, counters and inputs.
- FSM:
  - IDLE: on enable_in high -> SYNC_WAIT (counters start at 0 that cycle).
  - SYNC_WAIT:
    - ready = valid&&!sof (flush stale pixels).
    - A sof pixel is held (ready 0) until h==0&&v==0; it is consumed then (ready 1) and state -> RUN.
    - Outputs during SYNC_WAIT: normal timing, FILL_RGB when active.
  - RUN:
    - ready = active && !(valid && sof && !(h==0&&v==0)).
    - Active & valid: drive pixel.
    - Active & !valid: drive FILL_RGB, set underflow.
    - sof seen off (0,0): not consumed, drive FILL_RGB, set misalign, -> SYNC_WAIT.
    - valid non-sof pixel at (0,0): consume it, set misalign, stay RUN.
  - Any state: enable_in low -> IDLE next cycle, with IDLE output values.
- Blanking cycles: ready 0 in all states; data outputs 0.
- Simultaneous events: valid&ready only transfers in active or sync-consume cycles. clear and set in the same cycle: flag stays 1.

Decomposition:
- Shared package hdmi_pkg:
  - 720p timing constants.
  - FSM state encoding (IDLE, SYNC_WAIT, RUN).
  - Channel-to-colour mapping (ch0=B, ch1=G, ch2=R).
  - Count widths.
- Sub-module video_timing_gen: h/v counters plus active/hsync/vsync decode, with enable and synchronous clear.

Test Plan:
Use small timing: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), polarities 1, 98 cycles per frame.
1. Reset, then enable with pix_valid_in=0 -> stays SYNC_WAIT, blanking_out low for 8 of every 14 cycles on lines 0-3. ch0_ctrl_out=2'b01 for h=10-11, 2'b10 on line 5 (2'b11 at h=10-11 there). frame_start_out every 98 cycles.
2. Stream 32 pixels (first with sof, data = index) always valid -> first pixel consumed at counter (0,0). ch0_data_out=0x00 at frame_start_out. No flags set; ready low in blanking.
3. During RUN drop pix_valid_in for h=3 on line 1 -> ch*_data_out = FILL_RGB that cycle, underflow_out=1 and stays set. clear_flags_in pulse -> 0.
4. Present sof at (5,2) in RUN -> pixel not consumed, misalign_out=1, state SYNC_WAIT. That pixel is consumed at next (0,0) and shown with the next frame_start_out.
5. Drop enable_in mid-line (h=6,v=2), re-raise 3 cycles later -> outputs reach reset values one cycle after the drop; counters restart at 0 and frame_start_out asserts 1 cycle after re-enable.
6. Assert rst_n_in mid-active-pixel -> all outputs reach reset values asynchronously; clear_flags_in and an underflow in the same cycle leave underflow_out=1.
